sd_image_loader: RTL
====================

# sd_image_loader

Boot-time copy engine that streams a fixed-size binary image word by word from the SD-card cache RAM (sdcram) into main DRAM, then raises a sticky done flag. It sits between the sdcram read port and the DRAM write port of the SD-card peripheral. While `o_done` is low it owns the sdcram read port; once `o_done` rises, the peripheral hands that port to the runtime SD controller.

## Interface
Parameters:
- `SRC_BASE`, 41'h0: sdcram byte address of the first image word.
- `DST_BASE`, 32'h8000_0000: DRAM byte address of the first image word.
- `IMAGE_BYTES`, 32'h0080_0000: image length in bytes; must be a multiple of 4; 0 is legal.

Ports:
- `CLK`  in  1  system clock.
- `RST_X`  in  1  reset; one clock; reset is asynchronous and active-low.
- `o_sd_addr`  out  41  sdcram byte address.
- `o_sd_ren`  out  1  sdcram read strobe, one-cycle pulse.
- `i_sd_rdata`  in  32  sdcram read data.
- `i_sd_busy`  in  1  sdcram busy.
- `o_addr`  out  32  DRAM write byte address.
- `o_data`  out  32  DRAM write data.
- `o_we`  out  1  DRAM write strobe, one-cycle pulse.
- `i_dram_busy`  in  1  DRAM busy.
- `o_done`  out  1  copy complete; sticky until reset.
- `o_checksum`  out  32  running 32-bit sum of written words.

## Operation
- Word index `idx` is 30 bits wide. Last index is `IMAGE_BYTES/4 - 1`.
- Addresses: `o_sd_addr = SRC_BASE + 4*idx`; `o_addr = DST_BASE + 4*idx`. Both use modular width arithmetic and wrap silently.
- State machine:
  - **INIT**: entered on reset. After 1 cycle, go to DONE if `IMAGE_BYTES==0`, else to RD_REQ.
  - **RD_REQ**: when `i_sd_busy==0`, pulse `o_sd_ren` and go to RD_GAP.
  - **RD_GAP**: 1 cycle, so that sdcram busy is visible. Go to RD_WAIT.
  - **RD_WAIT**: when `i_sd_busy==0`, latch `i_sd_rdata` into the data register and go to WR_REQ.
  - **WR_REQ**: when `i_dram_busy==0`, pulse `o_we` with `o_addr`/`o_data` valid that same cycle. Add the word to the checksum and go to WR_GAP.
  - **WR_GAP**: 1 cycle. If `idx` is the last index, go to DONE. Otherwise increment `idx` and go to RD_REQ.
  - **DONE**: terminal. `o_done=1`; no further strobes are issued.
- Exactly one sdcram read is outstanding at a time, and exactly one DRAM write per word read. Each word is read once and written once.
- `o_sd_addr` holds its value from RD_REQ through RD_WAIT. `o_addr`/`o_data` hold their values from WR_REQ through WR_GAP.
- Busy is sampled only in the REQ and WAIT states. A busy level seen in a GAP state is ignored.

## Timing
- Reset values: `o_sd_ren=0`, `o_we=0`, `o_done=0`, `o_sd_addr=SRC_BASE`, `o_addr=DST_BASE`, `o_data=0`, `o_checksum=0`, `idx=0`, state INIT.
- Strobes are registered outputs, high for exactly one cycle per transfer.
- Per-word latency with both busy signals low (RD_WAIT satisfied on first cycle) is 5 cycles, so strobes repeat every 5 cycles.
- Each busy stall adds one cycle per stalled cycle, in the state where it occurs.
- `o_done` rises in the cycle after the final WR_GAP. Total minimum time is 1 + 5·N cycles after reset release, where N = `IMAGE_BYTES/4`.
- Reset mid-copy: all outputs return asynchronously to their reset values. The copy restarts from `idx=0`; partially written DRAM contents are not rolled back.
- If `i_sd_busy` and `i_dram_busy` are both high, only the busy signal relevant to the current state has any effect.

## Configuration
- `SD_LOADER_CHECKSUM_EN` defined:
  - `o_checksum` accumulates (mod 2^32) each word at its WR_REQ strobe.
  - The value is frozen once `o_done` rises.
- Not defined:
  - `o_checksum` is constant 0 and no adder is synthesized.
  - All other behaviour is identical.

## Test plan
- `IMAGE_BYTES=16`, sdcram returns 0x11,0x22,0x33,0x44, no busy → four `o_we` pulses at 0x8000_0000/04/08/0C with matching data, spaced 5 cycles apart; `o_done` high at cycle 21 after reset; checksum 0xAA when the macro is defined.
- `i_sd_busy` held high 10 cycles after each `o_sd_ren` → data is captured only when busy drops; per-word spacing grows to 14 cycles; no duplicate `o_sd_ren`.
- `i_dram_busy` high for 7 cycles during a WR_REQ → `o_we` is delayed exactly 7 cycles and fires once; address and data are unchanged.
- `IMAGE_BYTES=0` → no strobes at all; `o_done=1` 1 cycle after reset release.
- `RST_X` asserted after word 2 of 4, then released → outputs clear immediately; the copy restarts at 0x8000_0000 and writes all 4 words; `o_done` rises once.
- `SRC_BASE=41'h1FF_FFFF_FFFC`, 2 words → the second read is issued at `o_sd_addr=0`, showing the modular wrap.

Source files
------------

// File: rtl/sd_image_loader.sv
// Boot-time copy engine: streams IMAGE_BYTES from sdcram into DRAM one word at a time, then sets a sticky done flag.
// Optional running checksum of written words is enabled by defining SD_LOADER_CHECKSUM_EN.
module sd_image_loader #(
    parameter logic [40:0] SRC_BASE    = 41'h0,
    parameter logic [31:0] DST_BASE    = 32'h8000_0000,
    parameter logic [31:0] IMAGE_BYTES = 32'h0080_0000
) (
    input  logic        CLK,
    input  logic        RST_X,
    output logic [40:0] o_sd_addr,
    output logic        o_sd_ren,
    input  logic [31:0] i_sd_rdata,
    input  logic        i_sd_busy,
    output logic [31:0] o_addr,
    output logic [31:0] o_data,
    output logic        o_we,
    input  logic        i_dram_busy,
    output logic        o_done,
    output logic [31:0] o_checksum
);

    typedef enum logic [2:0] {
        S_INIT,
        S_RD_REQ,
        S_RD_GAP,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_GAP,
        S_DONE
    } state_t;

    localparam logic [29:0] LAST_IDX = IMAGE_BYTES[31:2] - 30'd1;

    state_t      state;
    logic [29:0] idx;
    logic [29:0] idx_nxt;

    assign idx_nxt = idx + 30'd1;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state     <= S_INIT;
            idx       <= '0;
            o_sd_addr <= SRC_BASE;
            o_sd_ren  <= 1'b0;
            o_addr    <= DST_BASE;
            o_data    <= '0;
            o_we      <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            o_sd_ren <= 1'b0;
            o_we     <= 1'b0;
            case (state)
                S_INIT: begin
                    if (IMAGE_BYTES == 32'd0) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else begin
                        state <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (!i_sd_busy) begin
                        o_sd_ren <= 1'b1;
                        state    <= S_RD_GAP;
                    end
                end
                S_RD_GAP: state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (!i_sd_busy) begin
                        o_data <= i_sd_rdata;
                        state  <= S_WR_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (!i_dram_busy) begin
                        o_we  <= 1'b1;
                        state <= S_WR_GAP;
                    end
                end
                S_WR_GAP: begin
                    // Addresses advance here so both stay stable across the whole read and write phases.
                    if (idx == LAST_IDX) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end else begin
                        idx       <= idx_nxt;
                        o_sd_addr <= SRC_BASE + {9'd0, idx_nxt, 2'b00};
                        o_addr    <= DST_BASE + {idx_nxt, 2'b00};
                        state     <= S_RD_REQ;
                    end
                end
                S_DONE: state <= S_DONE;
                default: state <= S_INIT;
            endcase
        end
    end

`ifdef SD_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            o_checksum <= '0;
        end else if (state == S_WR_REQ && !i_dram_busy) begin
            o_checksum <= o_checksum + o_data;
        end
    end
`else
    assign o_checksum = '0;
`endif

endmodule
